// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states,
// immediate-select codes and the opcode/funct3 pairs it understands.
package ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_TRAP   = 3'd4;

  localparam logic [1:0] IMM_NONE = 2'b00;
  localparam logic [1:0] IMM_I    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction classifier: ADDI, BNE or illegal,
// looked at from the latched IR only.
import ctrl_pkg::*;

module ctrl_decoder (
  input  logic [31:0] ir,
  output logic        is_addi,
  output logic        is_bne,
  output logic        is_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       ir_unused;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];

  // Register and immediate fields do not affect classification.
  assign ir_unused = ^{ir[31:15], ir[11:7]};

  assign is_addi    = (opcode == OP_ADDI) && (funct3 == F3_ADDI);
  assign is_bne     = (opcode == OP_BNE) && (funct3 == F3_BNE);
  assign is_illegal = !(is_addi || is_bne);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IDLE/FETCH/DECODE/EXEC/TRAP controller for ADDI and BNE,
// with a sticky illegal trap and a wrapping retired-instruction counter.
import ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  input  logic             eq,
  output logic             ir_load,
  output logic [1:0]       imm_src,
  output logic             alu_src,
  output logic             reg_write,
  output logic             pc_en,
  output logic             pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;
  logic        is_addi;
  logic        is_bne;
  logic        is_illegal;
  logic        in_exec;

  ctrl_decoder u_dec (
    .ir         (ir),
    .is_addi    (is_addi),
    .is_bne     (is_bne),
    .is_illegal (is_illegal)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (imem_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = is_illegal ? S_TRAP : S_EXEC;
      S_EXEC:   state_nxt = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= imem_rdata;
      if (in_exec) retired <= retired + 1'b1;
    end
  end

  // Strobes come from state and the latched IR, so reset kills them at once.
  assign in_exec   = (state == S_EXEC);
  assign imem_req  = (state == S_FETCH);
  assign ir_load   = imem_req && imem_valid;
  assign alu_src   = in_exec && is_addi;
  assign reg_write = in_exec && is_addi;
  assign pc_en     = in_exec && (is_addi || is_bne);
  assign pc_src    = in_exec && is_bne && !eq;
  assign illegal   = (state == S_TRAP);

  always_comb begin
    imm_src = IMM_NONE;
    unique case (1'b1)
      in_exec && is_addi: imm_src = IMM_I;
      in_exec && is_bne:  imm_src = IMM_B;
      default:            imm_src = IMM_NONE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl (CNT_W=4),
// checked against a per-instruction transaction model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        eq = 1'b0;
  logic        imem_req;
  logic        ir_load;
  logic [1:0]  imm_src;
  logic        alu_src;
  logic        reg_write;
  logic        pc_en;
  logic        pc_src;
  logic        illegal;
  logic [3:0]  retired;

  int          nerr = 0;
  int          nchk = 0;
  int unsigned model_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .eq         (eq),
    .ir_load    (ir_load),
    .imm_src    (imm_src),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .retired    (retired)
  );

  localparam logic [8:0] O_IDLE  = 9'b0_0_00_0_0_0_0_0;
  localparam logic [8:0] O_WAIT  = 9'b1_0_00_0_0_0_0_0;
  localparam logic [8:0] O_FETCH = 9'b1_1_00_0_0_0_0_0;
  localparam logic [8:0] O_TRAP  = 9'b0_0_00_0_0_0_0_1;

  function automatic logic [8:0] obs();
    return {imem_req, ir_load, imm_src, alu_src,
            reg_write, pc_en, pc_src, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // 0 = ADDI, 1 = BNE, 2 = illegal
  function automatic int cls(input logic [31:0] w);
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return 0;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return 1;
    return 2;
  endfunction

  function automatic logic [8:0] exp_exec(input int c, input logic e);
    if (c == 0) return 9'b0_0_01_1_1_1_0_0;
    return {2'b00, 2'b10, 1'b0, 1'b0, 1'b1, ~e, 1'b0};
  endfunction

  function automatic logic [31:0] rand_instr(input bit bne);
    logic [31:0] r;
    r = $urandom & 32'hFFFF_8F80;
    return bne ? (r | 32'h0000_1063) : (r | 32'h0000_0013);
  endfunction

  // Entered in the first FETCH cycle; leaves in FETCH, IDLE or TRAP.
  task automatic do_instr(input logic [31:0] w, input logic e,
                          input int waits, input logic run_after);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      run = 1'($urandom_range(0, 1));
      #1 chk("fetch_wait", obs(), O_WAIT);
      step();
    end
    imem_valid = 1'b1;
    imem_rdata = w;
    #1 chk("fetch_load", obs(), O_FETCH);
    step();
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    run = run_after;
    #1 chk("decode", obs(), O_IDLE);
    step();
    if (cls(w) == 2) return;
    eq = e;
    #1 chk("exec", obs(), exp_exec(cls(w), e));
    chk("ret_pre", retired, model_ret);
    step();
    model_ret = (model_ret + 1) % 16;
    chk("retired", retired, model_ret);
    imem_valid = 1'b0;
    #1 chk(run_after ? "refetch" : "idle_after", obs(),
           run_after ? O_WAIT : O_IDLE);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    imem_valid = 1'b0;
    #1 chk("rst_out", obs(), O_IDLE);
    chk("rst_ret", retired, 0);
    model_ret = 0;
    step();
    rst = 1'b1;
    run = 1'b1;
    #1 chk("idle_run", obs(), O_IDLE);
    step();
  endtask

  initial begin
    do_reset();

    do_instr(32'h0050_0093, 1'b0, 0, 1'b1);
    chk("addi_ret1", retired, 1);
    do_instr(32'hFE00_9EE3, 1'b0, 0, 1'b1);
    do_instr(32'hFE00_9EE3, 1'b1, 0, 1'b1);
    do_instr(32'h0050_0093, 1'b0, 5, 1'b1);

    // run dropped in DECODE: retire, then IDLE until run returns
    do_instr(rand_instr(1'b1), 1'($urandom_range(0, 1)), 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      imem_valid = 1'($urandom_range(0, 1));
      #1 chk("idle_hold", obs(), O_IDLE);
    end
    run = 1'b1;
    step();

    // async reset during BNE EXEC
    imem_valid = 1'b1;
    imem_rdata = 32'hFE00_9EE3;
    step();
    imem_valid = 1'b0;
    step();
    eq = 1'b0;
    #1 chk("bne_exec_pc_en", pc_en, 1);
    #1 rst = 1'b0;
    #1 chk("async_pc_en", pc_en, 0);
    chk("async_idle", obs(), O_IDLE);
    chk("async_ret", retired, 0);
    model_ret = 0;
    step();
    rst = 1'b1;
    run = 1'b1;
    #1 chk("rel_idle", obs(), O_IDLE);
    step();

    for (int i = 0; i < 16; i++)
      do_instr(rand_instr(1'b0), 1'b0, $urandom_range(0, 2), 1'b1);
    chk("wrap16", retired, 0);

    for (int i = 0; i < 30; i++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      do_instr(rand_instr(b), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'b1);
    end

    do_instr(32'h0000_0033, 1'b0, 0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      run = 1'($urandom_range(0, 1));
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      eq = 1'($urandom_range(0, 1));
      #1 chk("trap", obs(), O_TRAP);
      chk("trap_ret", retired, model_ret);
      step();
    end
    rst = 1'b0;
    #1 chk("trap_clear", obs(), O_IDLE);
    chk("trap_clear_ret", retired, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
